mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/arb_fair_pick.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the instruction-fetch / LSU memory port arbiter.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    BUSY_IF  = 2'd2,
    BUSY_LSU = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  // Maximum back-to-back LSU grants while a fetch waits.
  localparam int LSU_BURST_MAX_DEF = 4;

  // Fetches always read a whole word.
  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/arb_fair_pick.sv
// Winner selection between fetch and LSU, with a saturating LSU streak
// counter that hands the port to a waiting fetch after a bounded LSU burst.
module arb_fair_pick
  import pipeline_pkg::*;
#(
  parameter int LSU_BURST_MAX = LSU_BURST_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic lsu_req,
  input  logic if_gnt,
  input  logic lsu_gnt,
  output logic pick_if,
  output logic pick_lsu
);

  localparam int SW = (LSU_BURST_MAX < 1) ? 1 : $clog2(LSU_BURST_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LSU_BURST_MAX);

  logic [SW-1:0] streak;

  // Saturating increment so the streak never wraps past the burst limit.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STREAK_MAX) ? v : v + SW'(1);
  endfunction

  // LSU wins by default; fetch wins when alone or once the LSU burst is used up.
  always_comb begin
    pick_if  = if_req & (~lsu_req | (streak == STREAK_MAX));
    pick_lsu = lsu_req & ~pick_if;
  end

  // Count LSU grants that made a fetch wait; any other grant restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (if_gnt) begin
      streak <= '0;
    end else if (lsu_gnt) begin
      streak <= if_req ? sat_inc(streak) : '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU.
// One transaction in flight at a time: request/grant, then one response.
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int LSU_BURST_MAX = LSU_BURST_MAX_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  arb_state_e state;
  arb_owner_e owner;
  logic       pick_if, pick_lsu;
  logic       sel_if, sel_lsu;
  logic       if_gnt, lsu_gnt;

  arb_fair_pick #(
    .LSU_BURST_MAX(LSU_BURST_MAX)
  ) u_pick (
    .clk      (clk_i),
    .rst      (rst_i),
    .if_req   (if_req_i),
    .lsu_req  (lsu_req_i),
    .if_gnt   (if_gnt),
    .lsu_gnt  (lsu_gnt),
    .pick_if  (pick_if),
    .pick_lsu (pick_lsu)
  );

  // Who drives the memory port: fresh arbitration in IDLE, the latched owner in PEND.
  always_comb begin
    sel_if  = 1'b0;
    sel_lsu = 1'b0;
    unique case (state)
      IDLE: begin
        sel_if  = pick_if;
        sel_lsu = pick_lsu;
      end
      PEND: begin
        sel_if  = (owner == OWN_IF);
        sel_lsu = (owner == OWN_LSU);
      end
      default: ;
    endcase
    if_gnt  = ~rst_i & sel_if & if_req_i & mem_gnt_i;
    lsu_gnt = ~rst_i & sel_lsu & lsu_req_i & mem_gnt_i;
  end

  // Memory request mux; everything is quiet while reset is held.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!rst_i) begin
      if (sel_lsu) begin
        mem_req_o   = lsu_req_i;
        mem_we_o    = lsu_we_i;
        mem_be_o    = lsu_be_i;
        mem_addr_o  = lsu_addr_i;
        mem_wdata_o = lsu_wdata_i;
      end else if (sel_if) begin
        mem_req_o  = if_req_i;
        mem_be_o   = FETCH_BE;
        mem_addr_o = if_addr_i;
      end
    end
  end

  // Grants and response routing; responses outside BUSY_* are dropped.
  always_comb begin
    if_gnt_o     = if_gnt;
    lsu_gnt_o    = lsu_gnt;
    if_rvalid_o  = ~rst_i & (state == BUSY_IF) & mem_rvalid_i;
    lsu_rvalid_o = ~rst_i & (state == BUSY_LSU) & mem_rvalid_i;
    if_rdata_o   = (~rst_i && state == BUSY_IF) ? mem_rdata_i : '0;
    lsu_rdata_o  = (~rst_i && state == BUSY_LSU) ? mem_rdata_i : '0;
  end

  // Transaction FSM: present, optionally wait for grant, then wait for the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= OWN_LSU;
    end else begin
      unique case (state)
        IDLE, PEND: begin
          if (if_gnt) begin
            state <= BUSY_IF;
          end else if (lsu_gnt) begin
            state <= BUSY_LSU;
          end else if (mem_req_o) begin
            state <= PEND;
            owner <= sel_lsu ? OWN_LSU : OWN_IF;
          end else begin
            // A pending owner that withdraws its request releases the port.
            state <= IDLE;
          end
        end
        BUSY_IF, BUSY_LSU: begin
          if (mem_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, lsu_req, lsu_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [3:0]  lsu_be;
  logic        if_gnt_o, if_rvalid_o, lsu_gnt_o, lsu_rvalid_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] if_rdata_o, lsu_rdata_o, mem_addr_o, mem_wdata_o;

  mem_port_arbiter #(.LSU_BURST_MAX(MAX)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .lsu_req_i    (lsu_req),
    .lsu_we_i     (lsu_we),
    .lsu_be_i     (lsu_be),
    .lsu_addr_i   (lsu_addr),
    .lsu_wdata_i  (lsu_wdata),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: which requester owns the in-flight transaction (0 none,
  // 1 fetch, 2 LSU), which one was presented but not yet granted, and how many
  // LSU grants in a row have made a fetch wait.
  int m_busy = 0;
  int m_pend = 0;
  int m_streak = 0;

  logic        o_if_gnt = 1'b0, o_lsu_gnt = 1'b0, o_if_rv = 1'b0, o_lsu_rv = 1'b0;
  logic        o_mem_we = 1'b0;
  logic [3:0]  o_mem_be = '0;
  logic [31:0] o_mem_addr = '0, o_if_rdata = '0;
  logic [15:0] gnt_hist = '0;
  int          gnt_cnt = 0;

  // One clock: check outputs mid-cycle against the model, advance the model,
  // then return just after the rising edge so the caller can drive new inputs.
  task automatic cyc();
    int   who;
    logic e_ig, e_lg, e_ir, e_lr, e_req;
    @(negedge clk);
    o_if_gnt   = if_gnt_o;
    o_lsu_gnt  = lsu_gnt_o;
    o_if_rv    = if_rvalid_o;
    o_lsu_rv   = lsu_rvalid_o;
    o_mem_we   = mem_we_o;
    o_mem_be   = mem_be_o;
    o_mem_addr = mem_addr_o;
    o_if_rdata = if_rdata_o;
    who = 0;
    e_ig = 1'b0; e_lg = 1'b0; e_ir = 1'b0; e_lr = 1'b0;
    if (rst) begin
      chk("rst_ctl", 128'({if_gnt_o, if_rvalid_o, lsu_gnt_o, lsu_rvalid_o, mem_req_o}), 128'(0));
      chk("rst_data", 128'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, if_rdata_o, lsu_rdata_o}),
          128'(0));
      m_busy = 0; m_pend = 0; m_streak = 0;
    end else begin
      if (m_busy != 0) begin
        if (mem_rvalid) begin
          if (m_busy == 1) e_ir = 1'b1; else e_lr = 1'b1;
        end
      end else if (m_pend == 1) begin
        if (if_req) who = 1;
      end else if (m_pend == 2) begin
        if (lsu_req) who = 2;
      end else if (if_req && (!lsu_req || m_streak == MAX)) begin
        who = 1;
      end else if (lsu_req) begin
        who = 2;
      end
      e_req = (who != 0);
      if (who == 1 && mem_gnt) e_ig = 1'b1;
      if (who == 2 && mem_gnt) e_lg = 1'b1;
      chk("ctl", 128'({if_gnt_o, if_rvalid_o, lsu_gnt_o, lsu_rvalid_o, mem_req_o}),
          128'({e_ig, e_ir, e_lg, e_lr, e_req}));
      if (who == 1) chk("if_cmd", 128'({mem_we_o, mem_addr_o}), 128'({1'b0, if_addr}));
      if (who == 2) begin
        chk("lsu_cmd", 128'({mem_we_o, mem_addr_o}), 128'({lsu_we, lsu_addr}));
        if (lsu_we) chk("lsu_store", 128'({mem_be_o, mem_wdata_o}), 128'({lsu_be, lsu_wdata}));
      end
      if (e_ir) chk("if_rdata", 128'(if_rdata_o), 128'(mem_rdata));
      if (e_lr) chk("lsu_rdata", 128'(lsu_rdata_o), 128'(mem_rdata));
      if (m_busy != 0) begin
        if (mem_rvalid) m_busy = 0;
      end else if (who == 0) begin
        m_pend = 0;
      end else if (mem_gnt) begin
        m_busy = who;
        m_pend = 0;
        if (who == 1) m_streak = 0;
        else if (if_req) m_streak = (m_streak < MAX) ? m_streak + 1 : MAX;
        else m_streak = 0;
      end else begin
        m_pend = who;
      end
    end
    if (o_if_gnt || o_lsu_gnt) begin
      gnt_hist = {gnt_hist[14:0], o_if_gnt};
      gnt_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if_addr = '0; lsu_addr = '0; lsu_wdata = '0; mem_rdata = '0; lsu_be = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Single fetch: grant in cycle 0, data in cycle 1.
    if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
    cyc();
    chk("fetch_gnt", 128'({o_if_gnt, o_mem_addr}), 128'({1'b1, 32'h100}));
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    cyc();
    chk("fetch_rdata", 128'({o_if_rv, o_if_rdata}), 128'({1'b1, 32'hDEADBEEF}));
    chk("fetch_lsu_quiet", 128'({o_lsu_gnt, o_lsu_rv}), 128'(0));
    mem_rvalid = 1'b0;

    // Simultaneous requests: LSU first, fetch on the next IDLE cycle.
    if_req = 1'b1; if_addr = 32'h200; lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h300;
    mem_gnt = 1'b1;
    cyc();
    chk("both_lsu_first", 128'({o_lsu_gnt, o_if_gnt}), 128'(2'b10));
    lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    cyc();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    cyc();
    chk("both_if_next", 128'({o_lsu_gnt, o_if_gnt}), 128'(2'b01));
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    cyc();
    mem_rvalid = 1'b0;

    // Grant stall: the pending LSU load keeps the port while fetch appears.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h400;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        if_req = 1'b1; if_addr = 32'h500;
      end
      mem_gnt = (i == 3);
      cyc();
      chk("stall_addr", 128'(o_mem_addr), 128'(32'h400));
      chk("stall_gnt", 128'({o_lsu_gnt, o_if_gnt}), 128'({(i == 3), 1'b0}));
    end
    lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    cyc();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    cyc();
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    cyc();
    mem_rvalid = 1'b0;

    // Store with partial byte enables, acknowledged via lsu_rvalid.
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0011; lsu_wdata = 32'h12345678;
    lsu_addr = 32'h600; mem_gnt = 1'b1;
    cyc();
    chk("store_cmd", 128'({o_lsu_gnt, o_mem_we, o_mem_be}), 128'({1'b1, 1'b1, 4'b0011}));
    lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    cyc();
    chk("store_ack", 128'({o_lsu_rv, o_if_rv}), 128'(2'b10));
    mem_rvalid = 1'b0; lsu_we = 1'b0;

    // Reset in the middle of an LSU load (streak already 1), then a stray response.
    if_req = 1'b1; lsu_req = 1'b1; lsu_addr = 32'h700; mem_gnt = 1'b1;
    cyc();
    if_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_rvalid = 1'b1;
    cyc();
    chk("stray_rvalid", 128'({o_if_rv, o_lsu_rv}), 128'(0));
    mem_rvalid = 1'b0;

    // Fairness from a freshly cleared streak: L,L,L,L,I,L,L,L,L,I.
    gnt_hist = '0; gnt_cnt = 0;
    if_req = 1'b1; if_addr = 32'h800; lsu_req = 1'b1; lsu_addr = 32'h900;
    for (int k = 0; k < 10; k++) begin
      mem_gnt = 1'b1; mem_rvalid = 1'b0;
      cyc();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(k);
      cyc();
    end
    chk("fair_order", 128'(gnt_hist[9:0]), 128'(10'b0000100001));
    chk("fair_count", 128'(gnt_cnt), 128'(10));
    if_req = 1'b0; lsu_req = 1'b0; mem_rvalid = 1'b0;
    cyc();

    // Randomized traffic: requests held until granted, random grant/response
    // timing including stray responses, and occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      if (!if_req || o_if_gnt) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom;
      end
      if (!lsu_req || o_lsu_gnt) begin
        lsu_req   = 1'($urandom_range(0, 1));
        lsu_we    = 1'($urandom_range(0, 1));
        lsu_be    = 4'($urandom);
        lsu_addr  = $urandom;
        lsu_wdata = $urandom;
      end
      mem_gnt    = 1'($urandom_range(0, 1));
      mem_rvalid = ($urandom_range(0, 3) != 0);
      mem_rdata  = $urandom;
      rst        = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
